hazard_stall_ctrl: RTL and testbench

- Central pipeline scheduler for the 5-stage core.
- Drives the ID/EX bubble input (`nop`) and the write enables / flushes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Arbitrates stall sources: D-cache miss, I-cache miss, load-use hazard, taken branch, and halt.
- Decisions are combinational from a registered state plus current inputs; the stall counter is registered.

---
 rtl/hazard_stall_ctrl_if.sv | 40 ++++
 rtl/hazard_stall_ctrl.sv | 119 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Control bundle between the pipeline datapath (master) and the hazard/stall scheduler (slave).
// Signal names match the core's existing pipeline-register naming.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             IDEX_MemRead;
  logic [3:0]       IDEX_DstReg;
  logic [3:0]       IFID_SrcReg1;
  logic [3:0]       IFID_SrcReg2;
  logic             IFID_UsesSrc2;
  logic             BranchTaken;
  logic             HaltID;
  logic             HaltWB;
  logic             icache_miss;
  logic             dcache_miss;

  logic             nop;
  logic             PC_wen;
  logic             IFID_wen;
  logic             IFID_flush;
  logic             IDEX_wen;
  logic             EXMEM_wen;
  logic             MEMWB_wen;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output IDEX_MemRead, IDEX_DstReg, IFID_SrcReg1, IFID_SrcReg2, IFID_UsesSrc2,
           BranchTaken, HaltID, HaltWB, icache_miss, dcache_miss,
    input  nop, PC_wen, IFID_wen, IFID_flush, IDEX_wen, EXMEM_wen, MEMWB_wen,
           halted, stall_cycles
  );

  modport slave (
    input  IDEX_MemRead, IDEX_DstReg, IFID_SrcReg1, IFID_SrcReg2, IFID_UsesSrc2,
           BranchTaken, HaltID, HaltWB, icache_miss, dcache_miss,
    output nop, PC_wen, IFID_wen, IFID_flush, IDEX_wen, EXMEM_wen, MEMWB_wen,
           halted, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Central 5-stage pipeline scheduler: arbitrates cache misses, load-use, branch and halt
// into per-stage write enables, IF/ID flush and ID/EX bubble, plus a saturating stall counter.
module hazard_stall_ctrl #(
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  hazard_stall_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    RUN,
    DWAIT,
    IWAIT,
    HALTING,
    HALTED
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic load_use;
  logic nop, pc_wen, ifid_wen, ifid_flush, down_wen, halted;

  assign load_use = bus.IDEX_MemRead && (bus.IDEX_DstReg != 4'd0) &&
                    ((bus.IDEX_DstReg == bus.IFID_SrcReg1) ||
                     (bus.IFID_UsesSrc2 && (bus.IDEX_DstReg == bus.IFID_SrcReg2)));

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves one unassigned (no latches).
    state_d    = state_q;
    nop        = 1'b0;
    pc_wen     = 1'b1;
    ifid_wen   = 1'b1;
    ifid_flush = 1'b0;
    down_wen   = 1'b1;
    halted     = 1'b0;

    // While reset is asserted the pipe must run freely, whatever the stall inputs say.
    if (rst) begin
      unique case (state_q)
        HALTED: begin
          halted   = 1'b1;
          nop      = 1'b1;
          pc_wen   = 1'b0;
          ifid_wen = 1'b0;
          down_wen = 1'b0;
        end

        HALTING: begin
          if (bus.HaltWB) state_d = HALTED;
          if (bus.dcache_miss) begin
            pc_wen   = 1'b0;
            ifid_wen = 1'b0;
            down_wen = 1'b0;
          end else begin
            pc_wen     = 1'b0;
            ifid_flush = 1'b1;
          end
        end

        default: begin
          state_d = RUN;
          if (bus.dcache_miss) begin
            state_d  = DWAIT;
            pc_wen   = 1'b0;
            ifid_wen = 1'b0;
            down_wen = 1'b0;
          end else if (bus.icache_miss) begin
            // A load-use in ID keeps the stalled instruction instead of flushing it.
            state_d    = IWAIT;
            pc_wen     = 1'b0;
            nop        = load_use;
            ifid_wen   = !load_use;
            ifid_flush = !load_use;
          end else if (load_use) begin
            nop      = 1'b1;
            pc_wen   = 1'b0;
            ifid_wen = 1'b0;
          end else if (bus.BranchTaken) begin
            ifid_flush = 1'b1;
          end else if (bus.HaltID) begin
            state_d    = HALTING;
            pc_wen     = 1'b0;
            ifid_flush = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!pc_wen && (state_q != HALTED) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.nop          = nop;
  assign bus.PC_wen       = pc_wen;
  assign bus.IFID_wen     = ifid_wen;
  assign bus.IFID_flush   = ifid_flush;
  assign bus.IDEX_wen     = down_wen;
  assign bus.EXMEM_wen    = down_wen;
  assign bus.MEMWB_wen    = down_wen;
  assign bus.halted       = halted;
  assign bus.stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: two instances (16-bit and 4-bit counters) share stimulus,
// a rule-level reference model queues expected outputs and a monitor compares each cycle.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.CNT_W(16)) bus16 ();
  hazard_stall_ctrl_if #(.CNT_W(4))  bus4 ();

  hazard_stall_ctrl #(.CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  hazard_stall_ctrl #(.CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

  typedef struct packed {
    logic       r;
    logic       mr;
    logic [3:0] dst;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       u2;
    logic       br;
    logic       hid;
    logic       hwb;
    logic       im;
    logic       dm;
  } stim_t;

  // ctl = {nop, PC_wen, IFID_wen, IFID_flush, IDEX_wen, EXMEM_wen, MEMWB_wen, halted}
  typedef struct {
    logic [7:0] ctl;
    int         cnt;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_no = 0;

  // Reference model state: only halt progress and the raw stall count matter.
  bit m_halting = 1'b0;
  bit m_halted  = 1'b0;
  int m_cnt     = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.r = 1'b1;
    return s;
  endfunction

  task automatic check(input string name, input int cyc, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    rst                 = s.r;
    bus16.IDEX_MemRead  = s.mr;  bus4.IDEX_MemRead  = s.mr;
    bus16.IDEX_DstReg   = s.dst; bus4.IDEX_DstReg   = s.dst;
    bus16.IFID_SrcReg1  = s.s1;  bus4.IFID_SrcReg1  = s.s1;
    bus16.IFID_SrcReg2  = s.s2;  bus4.IFID_SrcReg2  = s.s2;
    bus16.IFID_UsesSrc2 = s.u2;  bus4.IFID_UsesSrc2 = s.u2;
    bus16.BranchTaken   = s.br;  bus4.BranchTaken   = s.br;
    bus16.HaltID        = s.hid; bus4.HaltID        = s.hid;
    bus16.HaltWB        = s.hwb; bus4.HaltWB        = s.hwb;
    bus16.icache_miss   = s.im;  bus4.icache_miss   = s.im;
    bus16.dcache_miss   = s.dm;  bus4.dcache_miss   = s.dm;
  endtask

  // Applies one cycle of stimulus and queues what the spec says the outputs must be.
  task automatic cyc(input stim_t s);
    bit   lu, nop, pc, ifw, fl, dn, hl, go_halt;
    exp_t e;
    @(posedge clk);
    #1;
    drive(s);
    cyc_no++;
    lu = s.mr && (s.dst != 0) && ((s.dst == s.s1) || (s.u2 && (s.dst == s.s2)));
    nop = 0; pc = 1; ifw = 1; fl = 0; dn = 1; hl = 0; go_halt = 0;
    if (!s.r) begin
      m_halting = 0;
      m_halted  = 0;
      m_cnt     = 0;
    end else if (m_halted) begin
      hl = 1; nop = 1; pc = 0; ifw = 0; dn = 0;
    end else if (s.dm) begin
      pc = 0; ifw = 0; dn = 0;
    end else if (m_halting) begin
      pc = 0; fl = 1;
    end else if (s.im) begin
      pc = 0;
      if (lu) begin nop = 1; ifw = 0; end
      else fl = 1;
    end else if (lu) begin
      nop = 1; pc = 0; ifw = 0;
    end else if (s.br) begin
      fl = 1;
    end else if (s.hid) begin
      pc = 0; fl = 1; go_halt = 1;
    end
    e.ctl = {nop, pc, ifw, fl, dn, dn, dn, hl};
    e.cnt = m_cnt;
    e.cyc = cyc_no;
    sb.push_back(e);
    if (s.r) begin
      if (!m_halted && !pc) m_cnt++;
      if (m_halting && s.hwb) m_halted = 1;
      if (go_halt) m_halting = 1;
    end
  endtask

  // Monitor: outputs are settled mid-cycle, so compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ctl16", e.cyc, int'({bus16.nop, bus16.PC_wen, bus16.IFID_wen, bus16.IFID_flush,
                                    bus16.IDEX_wen, bus16.EXMEM_wen, bus16.MEMWB_wen, bus16.halted}),
              int'(e.ctl));
        check("ctl4", e.cyc, int'({bus4.nop, bus4.PC_wen, bus4.IFID_wen, bus4.IFID_flush,
                                   bus4.IDEX_wen, bus4.EXMEM_wen, bus4.MEMWB_wen, bus4.halted}),
              int'(e.ctl));
        check("cnt16", e.cyc, int'(bus16.stall_cycles), (e.cnt > 65535) ? 65535 : e.cnt);
        check("cnt4", e.cyc, int'(bus4.stall_cycles), (e.cnt > 15) ? 15 : e.cnt);
      end
    end
  end

  initial begin
    stim_t s;
    drive(idle());
    rst = 1'b0;

    // Reset held with a D-miss pending, then release into RUN.
    s = idle(); s.r = 0; s.dm = 1;
    cyc(s); cyc(s);
    cyc(idle());

    // Load-use via rt, then clean cycle.
    s = idle(); s.mr = 1; s.dst = 4'd3; s.s1 = 4'd5; s.s2 = 4'd3; s.u2 = 1;
    cyc(s);
    cyc(idle());

    // Negatives: rt match without UsesSrc2, and DstReg 0.
    s = idle(); s.mr = 1; s.dst = 4'd3; s.s1 = 4'd5; s.s2 = 4'd3; s.u2 = 0;
    cyc(s);
    s = idle(); s.mr = 1; s.dst = 4'd0; s.s1 = 4'd0; s.s2 = 4'd0; s.u2 = 1;
    cyc(s);

    // D-miss overlapping a load-use, then the deferred bubble.
    s = idle(); s.mr = 1; s.dst = 4'd7; s.s1 = 4'd7; s.dm = 1;
    repeat (4) cyc(s);
    s.dm = 0;
    cyc(s);
    cyc(idle());

    // I-miss with a taken branch in its second cycle.
    s = idle(); s.im = 1;
    cyc(s);
    s.br = 1; cyc(s);
    s.br = 0; cyc(s);
    cyc(idle());

    // Halt: HLT in ID, drain, HaltWB three cycles later, stay halted, then reset.
    s = idle(); s.hid = 1;
    cyc(s);
    cyc(idle()); cyc(idle());
    s = idle(); s.hwb = 1;
    cyc(s);
    s = idle(); s.im = 1; s.br = 1;
    repeat (3) cyc(s);
    s = idle(); s.r = 0;
    cyc(s);
    cyc(idle());

    // Counter saturation on the 4-bit instance.
    s = idle(); s.im = 1;
    repeat (20) cyc(s);
    cyc(idle());

    // Randomized traffic with small register numbers to make hazards frequent.
    for (int i = 0; i < 800; i++) begin
      s.r   = ($urandom_range(0, 59) != 0);
      s.mr  = $urandom_range(0, 1) != 0;
      s.dst = 4'($urandom_range(0, 3));
      s.s1  = 4'($urandom_range(0, 3));
      s.s2  = 4'($urandom_range(0, 3));
      s.u2  = $urandom_range(0, 1) != 0;
      s.br  = $urandom_range(0, 3) == 0;
      s.hid = $urandom_range(0, 24) == 0;
      s.hwb = $urandom_range(0, 7) == 0;
      s.im  = $urandom_range(0, 5) == 0;
      s.dm  = $urandom_range(0, 7) == 0;
      cyc(s);
    end

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
